// File: rtl/parity_pkg.sv
// ----------------------------------------------------------------------------
// parity_pkg : state encodings and parity-mode constants shared by the
//              parity generator and the parity checker. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/parity_calc.sv
// ----------------------------------------------------------------------------
// parity_calc : combinational XOR reduction, shared by both link ends so the
//               parity rule is computed identically. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  parity
);

  assign parity = ^data;

endmodule

`default_nettype wire

// File: rtl/parity_checker_rx.sv
// ----------------------------------------------------------------------------
// parity_checker_rx : receives LSB-first serial frames plus a parity bit,
//                     flags parity errors and keeps a saturating count. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module parity_checker_rx #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8,
  parameter bit PARITY_ODD    = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     bit_valid,
  input  logic                     serial_in,
  output logic                     busy,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  output logic                     parity_error,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  import parity_pkg::*;

  localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    shift_parity;
  logic                    frame_err;
  logic                    take_data_bit;
  logic                    take_parity_bit;

  parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data   (shift_reg),
    .parity (shift_parity)
  );

  assign take_data_bit   = (state == DATA)   && bit_valid;
  assign take_parity_bit = (state == PARITY) && bit_valid;
  assign frame_err       = shift_parity ^ serial_in ^ PARITY_ODD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    data_valid = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = DATA;
      DATA:    if (bit_valid && (bit_cnt == LAST_BIT)) state_next = PARITY;
      PARITY:  if (bit_valid) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      shift_reg    <= '0;
      data_out     <= '0;
      parity_error <= 1'b0;
      err_count    <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end
      if (take_data_bit) begin
        shift_reg[bit_cnt] <= serial_in;
        bit_cnt            <= bit_cnt + CNT_W'(1);
      end
      if (take_parity_bit) begin
        data_out     <= shift_reg;
        parity_error <= frame_err;
        // Counter saturates; the per-frame flag is still reported.
        if (frame_err && (err_count != '1)) begin
          err_count <= err_count + ERR_CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_parity_checker_rx.sv
// ----------------------------------------------------------------------------
// tb_parity_checker_rx : even-parity and odd-parity/2-bit-counter instances
//                        driven together, checked through per-instance queues.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_parity_checker_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic serial_in = 1'b0;

  logic       busy_e, dv_e, pe_e;
  logic [7:0] dout_e, cnt_e;
  logic       busy_o, dv_o, pe_o;
  logic [7:0] dout_o;
  logic [1:0] cnt_o;

  always #5 clk = ~clk;

  parity_checker_rx #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .serial_in(serial_in),
    .busy(busy_e), .data_out(dout_e), .data_valid(dv_e), .parity_error(pe_e), .err_count(cnt_e)
  );

  parity_checker_rx #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .serial_in(serial_in),
    .busy(busy_o), .data_out(dout_o), .data_valid(dv_o), .parity_error(pe_o), .err_count(cnt_o)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cnt;
    int         cyc;
  } exp_t;

  exp_t q_even[$];
  exp_t q_odd[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   model_cnt_even = 0;
  int   model_cnt_odd = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference rule: total ones over data+parity must be even (even mode) or odd (odd mode).
  function automatic logic frame_bad(input logic [7:0] d, input logic p, input int odd);
    return ((($countones(d) + int'(p)) % 2) != odd);
  endfunction

  task automatic tick(input logic s, input logic v, input logic d);
    @(posedge clk);
    #1;
    start     = s;
    bit_valid = v;
    serial_in = d;
  endtask

  task automatic push_expected(input logic [7:0] d, input logic p);
    exp_t e;
    logic be, bo;
    be = frame_bad(d, p, 0);
    bo = frame_bad(d, p, 1);
    if (be) model_cnt_even = (model_cnt_even < 255) ? model_cnt_even + 1 : 255;
    if (bo) model_cnt_odd  = (model_cnt_odd  < 3)   ? model_cnt_odd + 1  : 3;
    e.data = d; e.cyc = cyc + 1;
    e.err = be; e.cnt = model_cnt_even; q_even.push_back(e);
    e.err = bo; e.cnt = model_cnt_odd;  q_odd.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int gap_max, input bit mid_start);
    int gaps;
    bit busy_checked;
    busy_checked = 1'b0;
    // bit_valid alongside start must not be captured.
    tick(1'b1, 1'b1, 1'($urandom % 2));
    for (int i = 0; i < 8; i++) begin
      gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      for (int g = 0; g < gaps; g++) begin
        tick(1'b0, 1'b0, 1'($urandom % 2));
        if (!busy_checked) begin
          check("busy_even_in_frame", 32'(busy_e), 32'd1);
          check("busy_odd_in_frame", 32'(busy_o), 32'd1);
          busy_checked = 1'b1;
        end
      end
      tick((mid_start && i == 3) ? 1'b1 : 1'b0, 1'b1, d[i]);
      if (!busy_checked) begin
        check("busy_even_in_frame", 32'(busy_e), 32'd1);
        check("busy_odd_in_frame", 32'(busy_o), 32'd1);
        busy_checked = 1'b1;
      end
    end
    tick(1'b0, 1'b1, p);
    push_expected(d, p);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (dv_e) begin
      if (q_even.size() == 0) begin
        checks++; failures++;
        $display("FAIL even_unexpected_valid actual=1 required=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q_even.pop_front();
        check("even_data_out", 32'(dout_e), 32'(e.data));
        check("even_parity_error", 32'(pe_e), 32'(e.err));
        check("even_err_count", 32'(cnt_e), 32'(e.cnt));
        check("even_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (dv_o) begin
      if (q_odd.size() == 0) begin
        checks++; failures++;
        $display("FAIL odd_unexpected_valid actual=1 required=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q_odd.pop_front();
        check("odd_data_out", 32'(dout_o), 32'(e.data));
        check("odd_parity_error", 32'(pe_o), 32'(e.err));
        check("odd_err_count", 32'(cnt_o), 32'(e.cnt));
        check("odd_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_busy_even"}, 32'(busy_e), 32'd0);
    check({tag, "_dout_even"}, 32'(dout_e), 32'd0);
    check({tag, "_pe_even"},   32'(pe_e),   32'd0);
    check({tag, "_cnt_even"},  32'(cnt_e),  32'd0);
    check({tag, "_dv_even"},   32'(dv_e),   32'd0);
    check({tag, "_busy_odd"},  32'(busy_o), 32'd0);
    check({tag, "_cnt_odd"},   32'(cnt_o),  32'd0);
    check({tag, "_dout_odd"},  32'(dout_o), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    send_frame(8'hAA, 1'b0, 0, 1'b0);
    send_frame(8'hBA, 1'b1, 0, 1'b0);
    send_frame(8'hBA, 1'b0, 0, 1'b0);
    send_frame(8'hAA, 1'b1, 0, 1'b0);

    // Abort a frame after four data bits.
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'($urandom % 2));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    model_cnt_even = 0;
    model_cnt_odd  = 0;
    tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    send_frame(8'h3C, 1'b0, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom);
      send_frame(d, 1'($urandom % 2), 3, 1'($urandom % 2));
    end

    // Bad frames for the odd-parity instance: parity bit makes the total even.
    for (int n = 0; n < 5; n++) begin
      d = 8'($urandom);
      send_frame(d, ^d, $urandom_range(2, 0), 1'b0);
    end
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check("odd_err_count_saturated", 32'(cnt_o), 32'd3);
    check("odd_parity_error_at_saturation", 32'(pe_o), 32'd1);
    check("even_queue_drained", 32'(q_even.size()), 32'd0);
    check("odd_queue_drained", 32'(q_odd.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
